// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame buffer RAM owner. Display fetches have strict
// priority over compute writes. Writes are queued in a small FIFO and drained into
// idle RAM cycles. The 160x120 buffer is upscaled to 640x480 by replicating pixels.
// Ports:
//   CLK_100MHz, reset          clock, asynchronous active-high reset
//   pix_x/pix_y/video_on/pix_stb  VGA timing inputs; pix_data/pix_valid fetched pixel
//   wr_valid/wr_addr/wr_data   compute write stream; wr_ready = FIFO not full
//   wr_err                     pulse when an out-of-range write is dropped
//   ram_*                      single-port RAM interface (read data one cycle later)
//   wq_level                   write FIFO occupancy
module fb_arbiter #(
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int AW          = 15,
   parameter int DW          = 4,
   parameter int WQ_DEPTH    = 4
) (
   input  logic                      CLK_100MHz,
   input  logic                      reset,
   input  logic [9:0]                pix_x,
   input  logic [9:0]                pix_y,
   input  logic                      video_on,
   input  logic                      pix_stb,
   output logic [DW-1:0]             pix_data,
   output logic                      pix_valid,
   input  logic                      wr_valid,
   input  logic [AW-1:0]             wr_addr,
   input  logic [DW-1:0]             wr_data,
   output logic                      wr_ready,
   output logic                      wr_err,
   output logic                      ram_en,
   output logic                      ram_we,
   output logic [AW-1:0]             ram_addr,
   output logic [DW-1:0]             ram_wdata,
   input  logic [DW-1:0]             ram_rdata,
   output logic [$clog2(WQ_DEPTH):0] wq_level
);

   localparam int PW = $clog2(WQ_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);

   typedef enum logic [1:0] {IDLE, RD, RD_WAIT} state_t;

   state_t          state;
   logic            rd_pending;
   logic [AW-1:0]   rd_addr;

   // write FIFO storage (no reset needed: occupancy qualifies every entry)
   logic [AW-1:0]   q_addr [WQ_DEPTH];
   logic [DW-1:0]   q_data [WQ_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   logic            trigger;
   logic            blank;
   logic [AW-1:0]   fetch_addr;
   logic            in_range;
   logic            do_push;
   logic            do_pop;
   logic            read_due;
   logic            q_empty;
   logic [AW-1:0]   head_addr;
   logic [DW-1:0]   head_data;
   logic [LW-1:0]   count_nxt;

   assign trigger    = pix_stb && video_on && (pix_x[SCALE_SHIFT-1:0] == '0);
   assign blank      = pix_stb && !video_on;
   // row multiply is done at AW bits; the largest address (19199) fits
   assign fetch_addr = AW'(pix_y >> SCALE_SHIFT) * AW'(FB_W) + AW'(pix_x >> SCALE_SHIFT);
   assign in_range   = (wr_addr < FB_SIZE);
   assign do_push    = wr_valid && wr_ready && in_range;

   // A fetch strobe arriving while IDLE is taken the same cycle, so the read
   // always wins over a queued write in that cycle.
   assign read_due   = rd_pending || trigger;
   assign q_empty    = (wq_level == '0);

   // With an empty queue the incoming write is forwarded straight to the RAM;
   // it is pushed and popped in the same cycle so occupancy stays at zero.
   assign do_pop     = (state == IDLE) && !read_due && (!q_empty || do_push);
   assign head_addr  = q_empty ? wr_addr : q_addr[rd_ptr];
   assign head_data  = q_empty ? wr_data : q_data[rd_ptr];
   assign count_nxt  = wq_level + LW'(do_push) - LW'(do_pop);

   always_ff @(posedge CLK_100MHz) begin
      if (do_push) begin
         q_addr[wr_ptr] <= wr_addr;
         q_data[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge CLK_100MHz or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rd_pending <= 1'b0;
         rd_addr    <= '0;
         pix_data   <= '0;
         pix_valid  <= 1'b0;
         wr_ready   <= 1'b0;
         wr_err     <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         wq_level   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         pix_valid <= 1'b0;
         // handshake completes even for dropped out-of-range writes
         wr_err    <= wr_valid && wr_ready && !in_range;
         wq_level  <= count_nxt;
         wr_ready  <= (count_nxt != LW'(WQ_DEPTH));
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

         case (state)
            IDLE: begin
               if (read_due) begin
                  state      <= RD;
                  ram_en     <= 1'b1;
                  ram_we     <= 1'b0;
                  // a fresh strobe supersedes an older pending address
                  ram_addr   <= trigger ? fetch_addr : rd_addr;
                  rd_pending <= 1'b0;
               end else if (do_pop) begin
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b1;
                  ram_addr  <= head_addr;
                  ram_wdata <= head_data;
               end else begin
                  ram_en <= 1'b0;
                  ram_we <= 1'b0;
               end
            end
            RD: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               state  <= RD_WAIT;
               if (trigger) begin
                  rd_pending <= 1'b1;
                  rd_addr    <= fetch_addr;
               end
            end
            RD_WAIT: begin
               ram_en    <= 1'b0;
               ram_we    <= 1'b0;
               pix_data  <= ram_rdata;
               pix_valid <= 1'b1;
               state     <= IDLE;
               if (trigger) begin
                  rd_pending <= 1'b1;
                  rd_addr    <= fetch_addr;
               end
            end
            default: begin
               state  <= IDLE;
               ram_en <= 1'b0;
               ram_we <= 1'b0;
            end
         endcase

         if (blank) pix_data <= '0;
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

   logic        clk;
   logic        reset;
   logic [9:0]  pix_x, pix_y;
   logic        video_on, pix_stb;
   logic [3:0]  pix_data;
   logic        pix_valid;
   logic        wr_valid;
   logic [14:0] wr_addr;
   logic [3:0]  wr_data;
   logic        wr_ready, wr_err;
   logic        ram_en, ram_we;
   logic [14:0] ram_addr;
   logic [3:0]  ram_wdata;
   logic [3:0]  ram_rdata;
   logic [2:0]  wq_level;

   fb_arbiter dut (
      .CLK_100MHz(clk), .reset(reset),
      .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on), .pix_stb(pix_stb),
      .pix_data(pix_data), .pix_valid(pix_valid),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_err(wr_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .wq_level(wq_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM attached to the DUT
   bit [3:0] ram_mem [32768];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   // reference model state
   int          checks, errors;
   int          cyc;
   int          acc, wseen;
   logic [18:0] exp_wq [$];
   bit   [3:0]  exp_ram [32768];
   logic [3:0]  exp_pix, pend_pix;
   logic [14:0] rd_exp_addr;
   int          rd_due, pix_due, blank_due, err_due;

   task automatic model_reset();
      acc = 0; wseen = 0; exp_wq.delete();
      rd_due = -1; pix_due = -1; blank_due = -1; err_due = -1;
      exp_pix = 4'h0; pend_pix = 4'h0;
   endtask

   // Advance one cycle: check outputs against the model, then drive inputs
   task automatic run_cycle(input logic stb, input logic vo, input logic [9:0] x,
                            input logic [9:0] y, input logic wv,
                            input logic [14:0] wa, input logic [3:0] wd);
      logic [18:0] w;
      int          lvl;
      @(negedge clk);
      cyc++;
      if (ram_en === 1'b1 && ram_we === 1'b1) begin
         wseen++;
         checks++;
         if (exp_wq.size() == 0) begin
            errors++;
            $display("FAIL ram_write cyc=%0d got addr=%0d data=%0h required none", cyc, ram_addr, ram_wdata);
         end else begin
            w = exp_wq.pop_front();
            exp_ram[w[18:4]] = w[3:0];
            if ({ram_addr, ram_wdata} !== w)
               begin errors++; $display("FAIL ram_write cyc=%0d got addr=%0d data=%0h required addr=%0d data=%0h", cyc, ram_addr, ram_wdata, w[18:4], w[3:0]); end
         end
      end
      checks++;
      if (cyc == rd_due) begin
         pend_pix = exp_ram[rd_exp_addr];
         if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === rd_exp_addr))
            begin errors++; $display("FAIL ram_read cyc=%0d got en=%b we=%b addr=%0d required read addr=%0d", cyc, ram_en, ram_we, ram_addr, rd_exp_addr); end
      end else if (ram_en === 1'b1 && ram_we !== 1'b1) begin
         errors++; $display("FAIL ram_read cyc=%0d got read addr=%0d required no read", cyc, ram_addr);
      end
      if (cyc == blank_due) exp_pix = 4'h0;
      if (cyc == pix_due)   exp_pix = pend_pix;
      checks++;
      if (pix_valid !== (cyc == pix_due) || pix_data !== exp_pix)
         begin errors++; $display("FAIL pix_out cyc=%0d got valid=%b data=%0h required valid=%b data=%0h", cyc, pix_valid, pix_data, (cyc == pix_due), exp_pix); end
      lvl = acc - wseen;
      checks++;
      if (wq_level !== 3'(lvl) || wr_ready !== (lvl != 4))
         begin errors++; $display("FAIL wq_level cyc=%0d got level=%0d ready=%b required level=%0d ready=%b", cyc, wq_level, wr_ready, lvl, (lvl != 4)); end
      checks++;
      if (wr_err !== (cyc == err_due))
         begin errors++; $display("FAIL wr_err cyc=%0d got %b required %b", cyc, wr_err, (cyc == err_due)); end
      // drive next inputs
      pix_stb = stb; video_on = vo; pix_x = x; pix_y = y;
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      if (wv && wr_ready === 1'b1) begin
         if (wa < 15'd19200) begin exp_wq.push_back({wa, wd}); acc++; end
         else err_due = cyc + 1;
      end
      if (stb && vo && x[1:0] == 2'b00) begin
         rd_due = cyc + 1; pix_due = cyc + 3;
         rd_exp_addr = 15'((y / 4) * 160 + (x / 4));
      end
      if (stb && !vo) blank_due = cyc + 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 15'd0, 4'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pix_stb = 0; video_on = 0; pix_x = 0; pix_y = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pix_data, pix_valid, wr_err, ram_en, ram_we, ram_addr, ram_wdata, wq_level} !== '0)
         begin errors++; $display("FAIL reset_outputs got pd=%0h pv=%b err=%b en=%b we=%b addr=%0d wd=%0h lvl=%0d required all zero", pix_data, pix_valid, wr_err, ram_en, ram_we, ram_addr, ram_wdata, wq_level); end
      reset = 1'b0;
      model_reset();
      idle(1);
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b required 1", wr_ready); end
   endtask

   task automatic test_read_path();
      run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 15'd161, 4'hA);
      idle(3);
      run_cycle(1'b1, 1'b1, 10'd4, 10'd4, 1'b0, 15'd0, 4'h0);
      idle(3);
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== 4'hA)
         begin errors++; $display("FAIL read_path got valid=%b data=%0h required valid=1 data=a", pix_valid, pix_data); end
   endtask

   task automatic test_replication();
      for (int x = 5; x <= 7; x++) begin
         run_cycle(1'b1, 1'b1, 10'(x), 10'd4, 1'b0, 15'd0, 4'h0);
         idle(3);
         checks++;
         if (pix_valid !== 1'b0 || pix_data !== 4'hA)
            begin errors++; $display("FAIL replication x=%0d got valid=%b data=%0h required valid=0 data=a", x, pix_valid, pix_data); end
      end
   endtask

   task automatic test_blank();
      run_cycle(1'b1, 1'b0, 10'd8, 10'd4, 1'b0, 15'd0, 4'h0);
      idle(1);
      checks++;
      if (pix_data !== 4'h0 || pix_valid !== 1'b0)
         begin errors++; $display("FAIL blank got valid=%b data=%0h required valid=0 data=0", pix_valid, pix_data); end
      idle(3);
   endtask

   task automatic test_out_of_range();
      logic [14:0] bad [2];
      bad[0] = 15'd19200; bad[1] = 15'd32767;
      for (int i = 0; i < 2; i++) begin
         run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, bad[i], 4'h7);
         idle(1);
         checks++;
         if (wr_err !== 1'b1 || wq_level !== 3'd0)
            begin errors++; $display("FAIL out_of_range addr=%0d got err=%b level=%0d required err=1 level=0", bad[i], wr_err, wq_level); end
         idle(2);
      end
   endtask

   task automatic test_priority();
      int nw, early;
      idle(2);
      for (int c = 0; c < 4; c++)
         run_cycle(c == 0, 1'b1, 10'd16, 10'd16, 1'b1, 15'(2000 + c), 4'(c + 1));
      run_cycle(1'b1, 1'b1, 10'd16, 10'd20, 1'b1, 15'd2004, 4'h5);
      checks++;
      if (wq_level !== 3'd3) begin errors++; $display("FAIL prio_level_at_stb got %0d required 3", wq_level); end
      nw = 0; early = 0;
      for (int k = 1; k <= 7; k++) begin
         run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 15'd0, 4'h0);
         if (ram_en === 1'b1 && ram_we === 1'b1) begin nw++; if (k < 4) early++; end
         if (k == 1) begin
            checks++;
            if (wq_level !== 3'd4) begin errors++; $display("FAIL prio_level_full got %0d required 4", wq_level); end
         end
      end
      checks++;
      if (nw != 4 || early != 0 || wq_level !== 3'd0)
         begin errors++; $display("FAIL prio_drain got writes=%0d early=%0d level=%0d required 4 0 0", nw, early, wq_level); end
   endtask

   task automatic test_backpressure();
      int kind, stalled, max_lvl, mism;
      logic [9:0] x, y;
      logic vo, wv;
      logic [14:0] wa;
      stalled = 0; max_lvl = 0; mism = 0;
      for (int p = 0; p < 60; p++) begin
         kind = $urandom_range(0, 99);
         y = 10'($urandom_range(0, 479));
         x = 10'($urandom_range(0, 159) * 4);
         vo = 1'b1;
         if (kind >= 85) vo = 1'b0;
         else if (kind >= 70) x = x + 10'($urandom_range(1, 3));
         for (int c = 0; c < 4; c++) begin
            wv = ($urandom_range(0, 9) < 8);
            wa = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(19200, 32767))
                                             : 15'($urandom_range(0, 19199));
            run_cycle(c == 0, vo, x, y, wv, wa, 4'($urandom));
            if (wv && wr_ready === 1'b0) stalled++;
            if (int'(wq_level) > max_lvl) max_lvl = int'(wq_level);
         end
      end
      for (int i = 0; i < 40 && acc != wseen; i++) idle(1);
      idle(2);
      checks++;
      if (acc != wseen || wq_level !== 3'd0)
         begin errors++; $display("FAIL bp_drain got written=%0d level=%0d required written=%0d level=0", wseen, wq_level, acc); end
      checks++;
      if (max_lvl != 4 || stalled == 0)
         begin errors++; $display("FAIL bp_full got max_level=%0d stalls=%0d required 4 and >0", max_lvl, stalled); end
      for (int i = 0; i < 32768; i++) if (ram_mem[i] !== exp_ram[i]) mism++;
      checks++;
      if (mism != 0) begin errors++; $display("FAIL bp_ram_contents got %0d differing words required 0", mism); end
   endtask

   task automatic test_reset_mid_read();
      idle(4);
      run_cycle(1'b1, 1'b1, 10'd8, 10'd8, 1'b1, 15'd1000, 4'h1);
      run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 15'd1001, 4'h2);
      run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 15'd1002, 4'h3);
      run_cycle(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 15'd1003, 4'h4);
      run_cycle(1'b1, 1'b1, 10'd8, 10'd8, 1'b0, 15'd0, 4'h0);
      idle(2);
      checks++;
      if (wq_level !== 3'd3 || ram_addr !== 15'd322)
         begin errors++; $display("FAIL rst_setup got level=%0d addr=%0d required level=3 addr=322", wq_level, ram_addr); end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({pix_data, pix_valid, wr_err, ram_en, ram_we, ram_addr, ram_wdata, wq_level} !== '0)
         begin errors++; $display("FAIL rst_mid_read got pd=%0h pv=%b en=%b addr=%0d lvl=%0d required all zero", pix_data, pix_valid, ram_en, ram_addr, wq_level); end
      model_reset();
      pix_stb = 0; wr_valid = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(6);
      checks++;
      if (wq_level !== 3'd0 || pix_valid !== 1'b0)
         begin errors++; $display("FAIL rst_after got level=%0d valid=%b required 0 0", wq_level, pix_valid); end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      model_reset();
      test_reset();
      test_read_path();
      test_replication();
      test_blank();
      test_out_of_range();
      test_priority();
      test_backpressure();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
